// File: rtl/seq_det_pkg.sv
// Shared state type and width helper for the parametrised serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module seq_det_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial pattern detector with runtime pattern/overlap config.
// Optional per-bit don't-care mask enabled by defining SEQ_DET_MASK_EN.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int unsigned  N       = 4,
    parameter int unsigned  CNT_W   = 8,
    parameter logic [N-1:0] PAT_RST = 4'b1011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_ld,
    input  logic [N-1:0]     cfg_pattern,
    input  logic             cfg_overlap,
`ifdef SEQ_DET_MASK_EN
    input  logic [N-1:0]     cfg_mask,
`endif
    input  logic             x,
    input  logic             x_vld,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int unsigned    FW       = clog2(N);
    localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);

    state_t          state_q, state_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [N-2:0]    window_q, window_d;
    logic [N-1:0]    pat_q;
    logic            ov_q;
    logic [N-1:0]    mask_q;
    logic [N-1:0]    cand;
    logic            hit;

`ifdef SEQ_DET_MASK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '1;
        end else if (cfg_ld) begin
            mask_q <= cfg_mask;
        end
    end
`else
    assign mask_q = '1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q <= PAT_RST;
            ov_q  <= 1'b1;
        end else if (cfg_ld) begin
            pat_q <= cfg_pattern;
            ov_q  <= cfg_overlap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            fill_q   <= '0;
            window_q <= '0;
            armed    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            window_q <= window_d;
            armed    <= (state_d == S_ARMED);
        end
    end

    always_comb begin
        cand     = {window_q, x};
        hit      = ((cand ^ pat_q) & mask_q) == '0;
        z        = x_vld & (state_q == S_ARMED) & hit & ~cfg_ld & ~reset;
        state_d  = state_q;
        fill_d   = fill_q;
        window_d = window_q;
        if (cfg_ld) begin
            state_d  = S_IDLE;
            fill_d   = '0;
            window_d = '0;
        end else if (x_vld) begin
            // slice of {window,x} keeps the shift legal for N == 2
            window_d = cand[N-2:0];
            if (z && !ov_q) begin
                fill_d  = '0;
                state_d = S_IDLE;
            end else begin
                if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
                state_d = (fill_d == FILL_MAX) ? S_ARMED : S_FILL;
            end
        end
    end

    seq_det_sat_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (z),
        .q     (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances (N=4/CNT_W=8, N=4/CNT_W=2, N=2)
// checked every cycle against a bit-history model, plus literal expectations.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset, cfg_ld, cfg_overlap, x, x_vld, cnt_clr;
    logic [3:0] cfg_pattern;
`ifdef SEQ_DET_MASK_EN
    logic [3:0] cfg_mask;
`endif
    logic       z_a, z_b, z_c, armed_a, armed_b, armed_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;

    int vectors = 0;
    int errors  = 0;
    int ncyc    = 0;
    logic [2:0] zs;

    // model state per instance: bits since last restart (newest LSB) and how many
    int MN[3]   = '{4, 4, 2};
    int MMAX[3] = '{255, 3, 255};
    int MRST[3] = '{11, 11, 2};
    int mh[3], mfill[3], mpat[3], mmask[3], mov[3], mcnt[3];

    always #5 clk = ~clk;

    seq_detect_param #(.N(4), .CNT_W(8), .PAT_RST(4'b1011)) dut_a (
        .clk(clk), .reset(reset), .cfg_ld(cfg_ld), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .x(x), .x_vld(x_vld), .cnt_clr(cnt_clr),
        .z(z_a), .match_cnt(cnt_a), .armed(armed_a)
    );

    seq_detect_param #(.N(4), .CNT_W(2), .PAT_RST(4'b1011)) dut_b (
        .clk(clk), .reset(reset), .cfg_ld(cfg_ld), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .x(x), .x_vld(x_vld), .cnt_clr(cnt_clr),
        .z(z_b), .match_cnt(cnt_b), .armed(armed_b)
    );

    seq_detect_param #(.N(2), .CNT_W(8), .PAT_RST(2'b10)) dut_c (
        .clk(clk), .reset(reset), .cfg_ld(cfg_ld), .cfg_pattern(cfg_pattern[1:0]),
        .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask(cfg_mask[1:0]),
`endif
        .x(x), .x_vld(x_vld), .cnt_clr(cnt_clr),
        .z(z_c), .match_cnt(cnt_c), .armed(armed_c)
    );

    task automatic chk(input string nm, input int act, input int req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    task automatic model_step();
        int n, full, cand, ze, az, aa, ac;
        for (int k = 0; k < 3; k++) begin
            n    = MN[k];
            full = (1 << n) - 1;
            cand = ((mh[k] << 1) | int'(x)) & full;
            ze   = (!reset && !cfg_ld && x_vld && (mfill[k] == n - 1) &&
                    (((cand ^ mpat[k]) & mmask[k]) == 0)) ? 1 : 0;
            case (k)
                0:       begin az = int'(z_a); aa = int'(armed_a); ac = int'(cnt_a); end
                1:       begin az = int'(z_b); aa = int'(armed_b); ac = int'(cnt_b); end
                default: begin az = int'(z_c); aa = int'(armed_c); ac = int'(cnt_c); end
            endcase
            if (ncyc > 0) begin
                chk($sformatf("model z[%0d]", k), az, ze);
                chk($sformatf("model armed[%0d]", k), aa, (mfill[k] == n - 1) ? 1 : 0);
                chk($sformatf("model match_cnt[%0d]", k), ac, mcnt[k]);
            end
            if (reset) begin
                mh[k] = 0; mfill[k] = 0; mpat[k] = MRST[k]; mmask[k] = full;
                mov[k] = 1; mcnt[k] = 0;
            end else begin
                if (cnt_clr) mcnt[k] = 0;
                else if (ze == 1 && mcnt[k] < MMAX[k]) mcnt[k]++;
                if (cfg_ld) begin
                    mpat[k] = int'(cfg_pattern) & full;
                    mov[k]  = int'(cfg_overlap);
`ifdef SEQ_DET_MASK_EN
                    mmask[k] = int'(cfg_mask) & full;
`else
                    mmask[k] = full;
`endif
                    mh[k] = 0; mfill[k] = 0;
                end else if (x_vld) begin
                    mh[k] = cand;
                    if (ze == 1 && mov[k] == 0) mfill[k] = 0;
                    else if (mfill[k] < n - 1) mfill[k]++;
                end
            end
        end
        ncyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        zs = {z_c, z_b, z_a};
        @(posedge clk);
        #1;
    endtask

    // one cycle with the given bit; one-shot controls drop afterwards
    task automatic put(input logic vb, input logic xb);
        x_vld = vb; x = xb;
        tick();
        x_vld = 1'b0; cfg_ld = 1'b0; cnt_clr = 1'b0; reset = 1'b0;
    endtask

    task automatic cfg_load(input logic [3:0] pat, input logic ov);
        cfg_pattern = pat; cfg_overlap = ov; cfg_ld = 1'b1;
        put(1'b0, 1'b0);
        cnt_clr = 1'b1;
        put(1'b0, 1'b0);
    endtask

    // first bit sent is bits[len-1]; zv bit i records z_a for bits[i]
    task automatic stream(input logic [7:0] bits, input int len, output logic [7:0] zv);
        logic [7:0] b;
        b  = bits;
        zv = '0;
        for (int i = len - 1; i >= 0; i--) begin
            put(1'b1, b[i]);
            zv[i] = zs[0];
        end
    endtask

    initial begin
        logic [7:0] zv;
        logic       gapz;
        logic [3:0] bits3;
        reset = 1'b1; cfg_ld = 1'b0; cfg_overlap = 1'b1; cfg_pattern = 4'b0000;
        x = 1'b0; x_vld = 1'b0; cnt_clr = 1'b0;
`ifdef SEQ_DET_MASK_EN
        cfg_mask = 4'b1111;
`endif
        tick(); reset = 1'b1; tick(); reset = 1'b0;
        chk("reset armed", int'(armed_a), 0);
        chk("reset match_cnt", int'(cnt_a), 0);

        // overlapping detection
        cfg_load(4'b1011, 1'b1);
        stream(8'b1011011, 7, zv);
        chk("t1 z bits", int'(zv[6:0]), 7'b0001001);
        chk("t1 match_cnt", int'(cnt_a), 2);

        // non-overlapping detection
        cfg_load(4'b1011, 1'b0);
        stream(8'b1011, 4, zv);
        chk("t2 z first4", int'(zv[3:0]), 4'b0001);
        chk("t2 armed after match", int'(armed_a), 0);
        stream(8'b011, 3, zv);
        chk("t2 z last3", int'(zv[2:0]), 3'b000);
        chk("t2 match_cnt", int'(cnt_a), 1);

        // gaps between valid bits; x held at 1 in gaps
        cfg_load(4'b1011, 1'b1);
        gapz  = 1'b0;
        bits3 = 4'b1011;
        zv    = '0;
        for (int i = 3; i >= 0; i--) begin
            put(1'b1, bits3[i]);
            zv[i] = zs[0];
            if (i > 0) begin
                for (int g = 0; g < 3; g++) begin
                    put(1'b0, 1'b1);
                    gapz = gapz | zs[0];
                end
            end
        end
        chk("t3 z bits", int'(zv[3:0]), 4'b0001);
        chk("t3 z in gaps", int'(gapz), 0);
        chk("t3 match_cnt", int'(cnt_a), 1);

        // saturation and clear priority
        cfg_load(4'b1111, 1'b1);
        stream(8'b11111111, 8, zv);
        chk("t4 z bits", int'(zv), 8'b00011111);
        chk("t4 cnt_b saturated", int'(cnt_b), 3);
        chk("t4 cnt_a", int'(cnt_a), 5);
        cnt_clr = 1'b1;
        put(1'b1, 1'b1);
        chk("t4 z with clr", int'(zs[0]), 1);
        chk("t4 cnt_a cleared", int'(cnt_a), 0);
        chk("t4 cnt_b cleared", int'(cnt_b), 0);

        // reset mid-stream; reset restores pattern 1011 overlap 1
        cfg_load(4'b0000, 1'b0);
        stream(8'b000, 3, zv);
        reset = 1'b1;
        put(1'b1, 1'b0);
        chk("t5 z during reset", int'(zs[0]), 0);
        chk("t5 armed after reset", int'(armed_a), 0);
        stream(8'b1011, 3, zv);
        cfg_load(4'b1011, 1'b1);
        stream(8'b101, 3, zv);
        reset = 1'b1;
        put(1'b1, 1'b1);
        chk("t5 z reset on final bit", int'(zs[0]), 0);
        put(1'b1, 1'b1);
        chk("t5 z first bit after reset", int'(zs[0]), 0);
        chk("t5 armed fill1", int'(armed_a), 0);
        stream(8'b01, 2, zv);
        chk("t5 armed fill3", int'(armed_a), 1);
        put(1'b1, 1'b1);
        chk("t5 z proves fill1", int'(zs[0]), 1);

        // cfg_ld together with the final bit
        cfg_load(4'b1011, 1'b1);
        stream(8'b101, 3, zv);
        cfg_pattern = 4'b1011; cfg_overlap = 1'b1; cfg_ld = 1'b1;
        put(1'b1, 1'b1);
        chk("t5 z with cfg_ld", int'(zs[0]), 0);
        chk("t5 armed after cfg_ld", int'(armed_a), 0);
        stream(8'b10, 2, zv);
        chk("t5 armed 2 bits", int'(armed_a), 0);
        put(1'b1, 1'b1);
        chk("t5 armed 3 bits", int'(armed_a), 1);

`ifdef SEQ_DET_MASK_EN
        cfg_mask = 4'b1001;
        cfg_load(4'b1001, 1'b0);
        stream(8'b1111, 4, zv);
        chk("t6 1111 masked", int'(zv[3:0]), 4'b0001);
        stream(8'b1001, 4, zv);
        chk("t6 1001 masked", int'(zv[3:0]), 4'b0001);
        stream(8'b0111, 4, zv);
        chk("t6 0111 masked", int'(zv[3:0]), 4'b0000);
        cfg_mask = 4'b0000;
        cfg_load(4'b0110, 1'b1);
        stream(8'b01101, 5, zv);
        chk("t6 mask zero", int'(zv[4:0]), 5'b00011);
        cfg_mask = 4'b1111;
`endif

        for (int i = 0; i < 4; i++) put(1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
